// File: rtl/mem_responder.sv
// Multicycle memory responder: one access per level-held strobe, fixed latency,
// registered one-cycle ready/err pulses, read data held until the next read completes.
module mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              imem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic rd_req, any_req, commit;

  // Handshake: the requester raises a strobe and holds it until it sees ready
  // (or err); one access is made per strobe assertion, and the strobe must
  // drop for at least one edge before the next request is accepted.
  assign rd_req    = mem_read | imem_read;
  assign any_req   = rd_req | mem_write;
  assign commit    = (state == WRITE_WAIT) && (cnt == '0);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // The array has no reset; a reset that leaves WRITE_WAIT also kills commit.
  always_ff @(posedge clock) begin
    if (commit) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req && !mem_write) begin
            addr_q <= addr;
            cnt    <= RD_INIT;
            state  <= READ_WAIT;
          end else if (mem_write && !rd_req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= WR_INIT;
            state   <= WRITE_WAIT;
          end else if (mem_write && rd_req) begin
            err   <= 1'b1;
            state <= RELEASE;
          end
        end
        READ_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rdata <= mem[addr_q];
            ready <= 1'b1;
            state <= RELEASE;
          end
        end
        WRITE_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ready <= 1'b1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (!any_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: default instance plus a WRITE_LAT=3 instance,
// scoreboarded read data and per-access ready/err/busy timing.
module tb_mem_responder;

  localparam int RLAT = 2;

  logic        clock = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        mem_read, imem_read, mem_write;
  logic [7:0]  addr;
  logic [31:0] wdata;

  logic        rd_a, ird_a, wr_a, rd_b, ird_b, wr_b;
  logic [31:0] rdata_a, rdata_b, rdata_s;
  logic        ready_a, ready_b, ready_s;
  logic        err_a, err_b, err_s;
  logic        busy_a, busy_b, busy_s;
  logic [1:0]  st_a, st_b, st_s;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [0:255];
  bit          written [0:255];

  always #5 clock = ~clock;

  assign rd_a  = mem_read  & ~sel;
  assign ird_a = imem_read & ~sel;
  assign wr_a  = mem_write & ~sel;
  assign rd_b  = mem_read  & sel;
  assign ird_b = imem_read & sel;
  assign wr_b  = mem_write & sel;

  assign rdata_s = sel ? rdata_b : rdata_a;
  assign ready_s = sel ? ready_b : ready_a;
  assign err_s   = sel ? err_b   : err_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign st_s    = sel ? st_b    : st_a;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
    .clock(clock), .reset(rst_a), .mem_read(rd_a), .imem_read(ird_a),
    .mem_write(wr_a), .addr(addr), .wdata(wdata), .rdata(rdata_a),
    .ready(ready_a), .err(err_a), .busy(busy_a), .state_dbg(st_a)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(2), .WRITE_LAT(3)) dut_b (
    .clock(clock), .reset(rst_b), .mem_read(rd_b), .imem_read(ird_b),
    .mem_write(wr_b), .addr(addr), .wdata(wdata), .rdata(rdata_b),
    .ready(ready_b), .err(err_b), .busy(busy_b), .state_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdata"}, rdata_s, 32'h0);
    check({tag, "_ready"}, 32'(ready_s), 32'h0);
    check({tag, "_err"},   32'(err_s), 32'h0);
    check({tag, "_busy"},  32'(busy_s), 32'h0);
    check({tag, "_state"}, 32'(st_s), 32'h0);
  endtask

  // kind: 0 mem_read, 1 imem_read, 2 both reads, 3 write, 4 read+write conflict
  task automatic access(input int kind, input logic [7:0] a, input logic [31:0] d,
                        input int hold, input bit wiggle);
    int lat, rdy_n, rdy_cnt, err_n, err_cnt, busy_fall;
    lat = (kind == 3) ? (sel ? 3 : 1) : RLAT;
    rdy_n = 0; rdy_cnt = 0; err_n = 0; err_cnt = 0; busy_fall = 0;
    @(negedge clock);
    addr      = a;
    wdata     = d;
    mem_read  = (kind == 0) || (kind == 2) || (kind == 4);
    imem_read = (kind == 1) || (kind == 2);
    mem_write = (kind == 3) || (kind == 4);
    if (kind <= 2) exp_q.push_back(model_mem[a]);
    @(posedge clock);
    for (int n = 1; n <= hold + 3; n++) begin
      @(negedge clock);
      if (ready_s) begin
        rdy_cnt++;
        if (rdy_n == 0) rdy_n = n;
        if (kind <= 2 && exp_q.size() > 0) check("rdata", rdata_s, exp_q.pop_front());
      end
      if (err_s) begin
        err_cnt++;
        if (err_n == 0) err_n = n;
      end
      if (!busy_s && busy_fall == 0) busy_fall = n;
      if (wiggle && n == 1) begin
        addr  = a ^ 8'h01;
        wdata = ~d;
      end
      if (n == hold) begin
        mem_read  = 1'b0;
        imem_read = 1'b0;
        mem_write = 1'b0;
      end
    end
    if (kind == 4) begin
      check("err_cnt", 32'(err_cnt), 32'd1);
      check("err_cycle", 32'(err_n), 32'd1);
      check("conflict_no_ready", 32'(rdy_cnt), 32'd0);
    end else begin
      check("ready_cnt", 32'(rdy_cnt), 32'd1);
      check("ready_cycle", 32'(rdy_n), 32'(lat + 1));
      check("no_err", 32'(err_cnt), 32'd0);
    end
    check("busy_fall", 32'(busy_fall), 32'(hold + 1));
    if (kind <= 2) begin
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    if (kind == 3) begin
      model_mem[a] = d;
      written[a]   = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra;
    logic [31:0] rd;
    sel = 1'b0; mem_read = 1'b0; imem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0; rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clock);
    check_zero("reset_a");
    sel = 1'b1;
    #1 check_zero("reset_b");
    sel = 1'b0;
    @(negedge clock);
    rst_a = 1'b1; rst_b = 1'b1;

    // write then read at defaults, and read data held across a later write
    access(3, 8'h10, 32'hDEADBEEF, 2, 1'b0);
    access(0, 8'h10, 32'h0, 3, 1'b0);
    access(3, 8'h20, 32'h5555AAAA, 2, 1'b0);
    access(3, 8'h11, 32'h0BADF00D, 2, 1'b0);
    repeat (2) @(negedge clock);
    check("rdata_held", rdata_s, 32'hDEADBEEF);

    access(0, 8'h10, 32'h0, 10, 1'b0);
    access(4, 8'h20, 32'h00001234, 2, 1'b0);
    access(0, 8'h20, 32'h0, 3, 1'b0);
    access(0, 8'h10, 32'h0, 3, 1'b1);
    access(0, 8'h11, 32'h0, 3, 1'b0);
    access(2, 8'h10, 32'h0, 3, 1'b0);
    access(1, 8'h11, 32'h0, 4, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(8'h40, 8'h47));
      if (!written[ra] || $urandom_range(0, 1) == 1)
        access(3, ra, $urandom, $urandom_range(2, 4), 1'b0);
      else
        access($urandom_range(0, 2), ra, 32'h0, $urandom_range(3, 5), 1'b0);
    end

    // reset while a read is in flight
    @(negedge clock);
    addr = 8'h10; mem_read = 1'b1;
    @(posedge clock);
    #2 rst_a = 1'b0;
    #1 check_zero("rst_mid_read");
    @(negedge clock); mem_read = 1'b0;
    @(negedge clock); rst_a = 1'b1;
    access(0, 8'h10, 32'h0, 3, 1'b0);

    // WRITE_LAT=3 instance: reset before the commit edge leaves memory unchanged
    sel = 1'b1;
    access(3, 8'h30, 32'h11112222, 4, 1'b0);
    access(0, 8'h30, 32'h0, 3, 1'b0);
    @(negedge clock);
    addr = 8'h30; wdata = 32'hAAAA5555; mem_write = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 check("wr_wait_state", 32'(st_s), 32'd2);
    #1 rst_b = 1'b0;
    #1 check_zero("rst_mid_write");
    @(negedge clock); mem_write = 1'b0;
    @(negedge clock); rst_b = 1'b1;
    access(0, 8'h30, 32'h0, 3, 1'b0);
    access(3, 8'h30, 32'hAAAA5555, 4, 1'b0);
    access(0, 8'h30, 32'h0, 3, 1'b0);
    rd = rdata_s;
    check("lat3_readback", rd, 32'hAAAA5555);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
